// File: rtl/pll_rst_ctrl_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings: lock
// status and restart requests in, PLL/system resets and health status out.
interface pll_rst_ctrl_if;
  logic       pll_lock;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic       loss_pulse;

  // master: the sequencer itself
  modport master (
    input  pll_lock, restart,
    output pll_rst, sys_rst_n, pll_ready, fault, retry_cnt, loss_cnt, loss_pulse
  );

  // slave: the PLL / system side that observes the sequencer
  modport slave (
    output pll_lock, restart,
    input  pll_rst, sys_rst_n, pll_ready, fault, retry_cnt, loss_cnt, loss_pulse
  );
endinterface

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock with
// bounded retries, releases the downstream reset and tracks lock losses.
module pll_rst_ctrl #(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 4096,
  parameter int LOCK_STABLE_CYC  = 64,
  parameter int MAX_RETRY        = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  pll_rst_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_HOLD, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  retry_cnt, retry_nxt;
  logic [7:0]  loss_cnt, loss_nxt;
  logic        loss_pulse, pulse_nxt;
  logic        lock_meta, lock_s;
  logic        pll_rst, sys_rst_n, pll_ready, fault;

  // pll_lock comes from the PLL's own domain; two flops before any decision.
  // NOTE: every flop here uses <= so all registers see the pre-edge values
  // of each other, regardless of block or statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // NOTE: all targets get a default before the case so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    pulse_nxt = 1'b0;

    if (bus.restart) begin
      state_nxt = S_HOLD;
      retry_nxt = 4'd0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // A lock seen in the timeout cycle still counts as a lock.
          if (lock_s) begin
            state_nxt = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt < RETRY_LIMIT) begin
              retry_nxt = retry_cnt + 4'd1;
              state_nxt = S_HOLD;
            end else begin
              state_nxt = S_FAULT;
            end
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = S_RUN;
            retry_nxt = 4'd0;
          end
        end
        S_RUN: begin
          cnt_nxt = cnt;
          if (!lock_s) begin
            state_nxt = S_HOLD;
            pulse_nxt = 1'b1;
            if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
          end
        end
        S_FAULT: cnt_nxt = cnt;
        default: state_nxt = S_HOLD;
      endcase
    end

    // restart while already in HOLD must still begin a fresh full hold.
    if (state_nxt != state || bus.restart) cnt_nxt = 16'd0;
  end

  // Outputs are decoded from the next state so they move with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HOLD;
      cnt        <= 16'd0;
      retry_cnt  <= 4'd0;
      loss_cnt   <= 8'd0;
      loss_pulse <= 1'b0;
      pll_rst    <= 1'b1;
      sys_rst_n  <= 1'b0;
      pll_ready  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      retry_cnt  <= retry_nxt;
      loss_cnt   <= loss_nxt;
      loss_pulse <= pulse_nxt;
      pll_rst    <= (state_nxt == S_HOLD) || (state_nxt == S_FAULT);
      sys_rst_n  <= (state_nxt == S_RUN);
      pll_ready  <= (state_nxt == S_RUN);
      fault      <= (state_nxt == S_FAULT);
    end
  end

  assign bus.pll_rst    = pll_rst;
  assign bus.sys_rst_n  = sys_rst_n;
  assign bus.pll_ready  = pll_ready;
  assign bus.fault      = fault;
  assign bus.retry_cnt  = retry_cnt;
  assign bus.loss_cnt   = loss_cnt;
  assign bus.loss_pulse = loss_pulse;

endmodule
